// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Segment codes are active-low with segment a in bit 6 and g in bit 0.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Indexed by nibble value: entry 0 is the code for '0', entry 15 is the code for 'F'.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low segment code; the blank input forces all segments off.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_OFF : HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Multiplexed common-anode 7-segment driver with PWM brightness, leading-zero
// blanking and display updates latched only at frame boundaries.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_CYCLES = 1024,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned PreW = $clog2(TICK_CYCLES);
  localparam int unsigned IdxW = idx_width(DIGITS);
  localparam logic [PreW-1:0]     PreMax = PreW'(TICK_CYCLES - 1);
  localparam logic [IdxW-1:0]     IdxMax = IdxW'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] SubMax = '1;

  logic [PreW-1:0]     pre_q, pre_d;
  logic [BRIGHT_W-1:0] sub_q, sub_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                tick, boundary;

  logic [DIGITS-1:0][3:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0][3:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic                   pend_v_q, pend_v_d;

  logic [DIGITS-1:0] blank_vec;
  logic              upper_nz;
  logic              digit_on;
  logic [6:0]        seg_dec;

  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d;

  // Scan counters: prescaler -> PWM sub-slot -> digit index.
  always_comb begin
    tick     = (pre_q == PreMax);
    boundary = tick && (sub_q == SubMax) && (idx_q == IdxMax);
    pre_d    = tick ? '0 : pre_q + PreW'(1);
    sub_d    = tick ? sub_q + BRIGHT_W'(1) : sub_q;
    idx_d    = idx_q;
    if (tick && (sub_q == SubMax)) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

  // A load on the boundary cycle bypasses the pending stage entirely.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_v_d    = pend_v_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (boundary) begin
      pend_v_d = 1'b0;
      if (load) begin
        disp_data_d = data_in;
        disp_dp_d   = dp_in;
      end else if (pend_v_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
      end
    end else if (load) begin
      pend_data_d = data_in;
      pend_dp_d   = dp_in;
      pend_v_d    = 1'b1;
    end
  end

  // Walk down from the top digit; a digit blanks while everything at and above it is zero.
  always_comb begin
    blank_vec = '0;
    upper_nz  = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      upper_nz     = upper_nz | (disp_data_d[k] != 4'h0);
      blank_vec[k] = lz_blank & ~upper_nz;
    end
  end

  // Outputs follow the data being written this edge so new data lands with frame_done.
  seg7_decoder u_decoder (
    .nibble (disp_data_d[idx_q]),
    .blank  (blank_vec[idx_q]),
    .seg    (seg_dec)
  );

  always_comb begin
    digit_on = (sub_q != '0) && (sub_q <= brightness);
    an_d     = '1;
    if (digit_on) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = seg_dec;
    dp_d  = ~disp_dp_d[idx_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q       <= '0;
      sub_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_v_q    <= pend_v_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_done  <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed plus randomized bench for seg7_mux_driver, checked every cycle against
// a frame-arithmetic reference model of the scan and the pending/display data.
module tb_seg7_mux_driver;

  localparam int D     = 4;
  localparam int T     = 4;
  localparam int BW    = 2;
  localparam int S     = 1 << BW;
  localparam int FRAME = D * S * T;

  logic          clock;
  logic          reset;
  logic [4*D-1:0] data_in;
  logic [D-1:0]  dp_in;
  logic          load;
  logic          lz_blank;
  logic [BW-1:0] brightness;
  logic [D-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  seg7_mux_driver #(
    .DIGITS      (D),
    .TICK_CYCLES (T),
    .BRIGHT_W    (BW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles since reset plus the architectural data registers.
  int unsigned    cnt;
  logic [4*D-1:0] m_disp, m_pend;
  logic [D-1:0]   m_disp_dp, m_pend_dp;
  bit             m_pend_v;
  logic [D-1:0]   e_an;
  logic [6:0]     e_seg;
  logic           e_dp, e_fd;

  // Segment patterns written active-high (a..g) and inverted for the pins.
  function automatic logic [6:0] hex_pins(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h7E; 4'h1: lit = 7'h30; 4'h2: lit = 7'h6D; 4'h3: lit = 7'h79;
      4'h4: lit = 7'h33; 4'h5: lit = 7'h5B; 4'h6: lit = 7'h5F; 4'h7: lit = 7'h70;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h7B; 4'hA: lit = 7'h77; 4'hB: lit = 7'h1F;
      4'hC: lit = 7'h4E; 4'hD: lit = 7'h3D; 4'hE: lit = 7'h4F; default: lit = 7'h47;
    endcase
    return ~lit;
  endfunction

  task automatic step();
    int  sub, idx;
    bit  bnd, on, blank;
    logic [4*D-1:0] upper;
    @(posedge clock);
    if (reset) begin
      cnt = 0;
      m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_pend_v = 0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      sub = (cnt / T) % S;
      idx = (cnt / (S * T)) % D;
      bnd = (cnt % FRAME) == FRAME - 1;
      if (bnd) begin
        if (load) begin
          m_disp = data_in; m_disp_dp = dp_in;
        end else if (m_pend_v) begin
          m_disp = m_pend; m_disp_dp = m_pend_dp;
        end
        m_pend_v = 0;
      end else if (load) begin
        m_pend = data_in; m_pend_dp = dp_in; m_pend_v = 1;
      end
      on    = (sub != 0) && (sub <= int'(brightness));
      e_an  = on ? ~(4'b0001 << idx) : 4'hF;
      upper = m_disp >> (4 * idx);
      blank = lz_blank && (idx != 0) && (upper == '0);
      e_seg = blank ? 7'h7F : hex_pins(upper[3:0]);
      e_dp  = ~m_disp_dp[idx];
      e_fd  = bnd;
      cnt++;
    end
    #1;
    vectors++;
    assert (an === e_an) else begin
      miscompares++;
      $error("FAIL an t=%0t observed=%b expected=%b", $time, an, e_an);
    end
    vectors++;
    assert (seg === e_seg) else begin
      miscompares++;
      $error("FAIL seg t=%0t observed=%h expected=%h", $time, seg, e_seg);
    end
    vectors++;
    assert (dp === e_dp) else begin
      miscompares++;
      $error("FAIL dp t=%0t observed=%b expected=%b", $time, dp, e_dp);
    end
    vectors++;
    assert (frame_done === e_fd) else begin
      miscompares++;
      $error("FAIL frame_done t=%0t observed=%b expected=%b", $time, frame_done, e_fd);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge falls at the given frame phase (at most one frame).
  task automatic run_to_phase(input int phase);
    for (int i = 0; i < FRAME && (cnt % FRAME) != phase; i++) step();
  endtask

  task automatic do_load(input logic [4*D-1:0] d, input logic [D-1:0] p);
    data_in = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_in = '0; dp_in = '0; load = 1'b0; lz_blank = 1'b0; brightness = 2'd3;
    cnt = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_pend_v = 0;

    // Reset held three cycles, then watch the first slot light up.
    run(3);
    reset = 1'b0;
    run(20);

    // Mid-frame load: only visible after the boundary.
    run_to_phase(30);
    do_load(16'h12A0, 4'b0100);
    run(2 * FRAME);

    // Leading-zero suppression.
    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1000);
    run(2 * FRAME);
    lz_blank = 1'b0;

    // Brightness extremes.
    do_load(16'h8421, 4'b0001);
    brightness = 2'd0;
    run(2 * FRAME);
    brightness = 2'd1;
    run(FRAME);
    brightness = 2'd3;

    // Two loads in one frame: the last one wins.
    run_to_phase(10);
    do_load(16'h1111, 4'b0001);
    run(5);
    do_load(16'h2222, 4'b0010);
    run(2 * FRAME);

    // Load exactly on the boundary cycle.
    run_to_phase(FRAME - 1);
    do_load(16'h9876, 4'b1010);
    run(FRAME + 4);

    // Reset during the idx=2 slot with a pending load.
    run_to_phase(2 * S * T + 3);
    do_load(16'hBEEF, 4'b1111);
    run(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 15) == 0);
      data_in = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 99) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 199) == 0) lz_blank = ~lz_blank;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    load = 1'b0;
    reset = 1'b0;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Parametrised multiplexed 7-segment driver for DIGITS common-anode digits, the generalised successor of the fixed four-digit driver. It scans one digit per slot and adds per-digit decimal points, PWM brightness, leading-zero blanking, anti-ghost blanking, and tear-free data updates latched at frame boundaries. It sits between the datapath (BCD/hex value plus load strobe) and the board anode/segment pins.

## Interface
- DIGITS, 4: number of digits scanned (≥2).
- TICK_CYCLES, 1024: clock cycles per PWM tick (≥2).
- BRIGHT_W, 4: brightness width; one digit slot is 2^BRIGHT_W ticks.

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- data_in  in  4*DIGITS  hex nibble per digit; nibble k drives digit k, and digit 0 is least significant.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- load  in  1  single-cycle strobe that captures data_in/dp_in into the pending register.
- lz_blank  in  1  enables leading-zero suppression.
- brightness  in  BRIGHT_W  on-ticks per slot; 0 means dark.
- an  out  DIGITS  anode enables, active-low.
- seg  out  7  segments, active-low; seg[6]=a … seg[0]=g.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Prescaler** `pre` counts 0..TICK_CYCLES-1 and wraps. `tick` is asserted when `pre`==TICK_CYCLES-1.
- **Slot counter** `sub` (BRIGHT_W bits) increments on `tick` and wraps.
- **Digit index** `idx` (0..DIGITS-1) increments on `tick` when `sub` is at its maximum, and wraps to 0.
- **Frame boundary**: `tick` && `sub`==max && `idx`==DIGITS-1.
- **Digit on-condition**: `sub`≠0 && `sub`≤brightness.
  - `sub`==0 is the anti-ghost blanking tick; all anodes are off during it.
  - brightness=0 means always off.
  - brightness=max means on for 2^BW−1 of 2^BW ticks.
- **Registers**: `pend_data`/`pend_dp`/`pend_v` and `disp_data`/`disp_dp`.
  - load sets `pend_v` and overwrites the pending values; the last load before a boundary wins.
  - At a frame boundary with `pend_v`=1: display ← pending, and `pend_v` clears.
  - load coinciding with a frame boundary: display ← data_in/dp_in directly, and `pend_v` stays 0.
  - brightness and lz_blank are sampled live, not latched.
- **Leading-zero suppression** (when lz_blank=1):
  - Digit k is blanked if it and every digit above it are 0.
  - Digit 0 is never blanked.
  - The dp of a blanked digit is still shown if requested.
- **Output of the active digit**:
  - an[idx]=0 when the on-condition holds; all other anodes are 1.
  - seg = hex decode of nibble idx (0–F), or all-off if blanked.
  - dp = ~disp_dp[idx].
- **Reset values**: an all 1s; seg 7'h7F; dp 1; frame_done 0; pre/sub/idx 0; all data registers 0; `pend_v` 0.

## Timing
- an, seg, dp and frame_done are registered: they reflect counter/display state with 1-cycle latency.
- frame_done is high the cycle after the boundary edge, i.e. in the same cycle the new display data first appears on seg.
- Frame length: DIGITS·2^BRIGHT_W·TICK_CYCLES cycles. Slot length: 2^BRIGHT_W·TICK_CYCLES cycles.
- load has no backpressure and is accepted every cycle. Data is visible on the pins no earlier than the next frame boundary.
- Reset asserted mid-frame: on the next edge all state returns to reset values and pending data is discarded. The scan restarts at digit 0, sub 0.
- A change to brightness takes effect on the next `sub` evaluation, 1-cycle latency to an.

## Structure
- Package `seg7_pkg` holds:
  - the 16-entry hex→segment constant table (active-low, a in bit 6);
  - SEG_OFF=7'h7F;
  - the digit-index width function ($clog2(DIGITS)).
- One combinational sub-module `seg7_decoder`: nibble + blank → seg[6:0].
- The top holds the prescaler, counters, pending/display registers, LZ logic and output registers.

## Test plan
Simulation parameters: DIGITS=4, TICK_CYCLES=4, BRIGHT_W=2, giving 16-cycle slots and 64-cycle frames.

- **Reset**: hold reset 3 cycles → an=4'b1111, seg=7'h7F, dp=1, frame_done=0. Release → first an=4'b1110 appears 5 cycles later, after tick 0 blank.
- **Load and scan**: load data_in=16'h12A0, dp_in=4'b0100, brightness=3 mid-frame.
  - Display is unchanged until frame_done.
  - Then digit 0 shows seg=0x01 (0), digit 1 shows A=0x08, digit 2 shows 2=0x12 with dp=0, digit 3 shows 1=0x4F.
  - Each digit is on 12 of 16 cycles.
- **Leading-zero suppression**: data 16'h0050, lz_blank=1 → digits 3 and 2 seg=7'h7F, digit 1 shows 5, digit 0 shows 0. With 16'h0000, only digit 0 is lit.
- **Brightness**: brightness=0 → an stays 4'b1111 a full frame. brightness=1 → each anode is low exactly 4 cycles per slot.
- **Load collisions**: two loads in one frame (16'h1111 then 16'h2222) → only 2222 is displayed. A load on the boundary cycle → displayed immediately, and the next frame is unchanged.
- **Mid-frame reset**: reset during the idx=2 slot with a pending load → outputs go to reset values and the pending data never appears.
